// File: rtl/epb_lb_pkg.sv
`default_nettype none
// ============================================================================
// epb_lb_pkg : state encoding, response data constants and select-width helper
// Rev 1.0
// ============================================================================
package epb_lb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STROBE   = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  // Wide enough for any supported data width; sliced to DW at the use site.
  localparam logic [63:0] ERR_DATA      = '1;
  localparam logic [63:0] UNMAPPED_DATA = '0;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/epb_lb_timeout.sv
`default_nettype none
// ============================================================================
// epb_lb_timeout : ack wait counter; load starts it at 1, expire at TIMEOUT
// Rev 1.0
// ============================================================================
module epb_lb_timeout #(
  parameter int TIMEOUT = 255,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [CW-1:0] count;

  assign expire = en && (count == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(1);
    end else if (en && !expire) begin
      count <= count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/epb_lb_bridge.sv
`default_nettype none
// ============================================================================
// epb_lb_bridge : registered EPB to N-slave local-bus transaction engine
// Optional ack timeout enabled by defining EPB_LB_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module epb_lb_bridge
  import epb_lb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int SLAVE_AW   = 3,
  parameter int DW         = 8,
  parameter int TIMEOUT    = 255,
  localparam int SEL_W     = sel_width(NUM_SLAVES)
) (
  input  logic                       lb_clk,
  input  logic                       lb_rst,
  input  logic                       epb_cs_n,
  input  logic                       epb_we_n,
  input  logic                       epb_be_n,
  input  logic [SEL_W+SLAVE_AW-1:0]  epb_addr,
  input  logic [DW-1:0]              epb_data_i,
  output logic [DW-1:0]              epb_data_o,
  output logic                       epb_data_oen,
  output logic                       epb_rdy,
  output logic                       bus_err,
  output logic [NUM_SLAVES-1:0]      lb_stb_o,
  output logic                       lb_we_o,
  output logic [SLAVE_AW-1:0]        lb_adr_o,
  output logic [DW-1:0]              lb_dat_o,
  input  logic [NUM_SLAVES*DW-1:0]   lb_dat_i,
  input  logic [NUM_SLAVES-1:0]      lb_ack_i
);

  state_t                state;
  logic                  armed;
  logic [SEL_W-1:0]      sel;
  logic [SEL_W-1:0]      addr_sel;
  logic                  mapped;
  logic [NUM_SLAVES-1:0] onehot;
  logic                  ack_sel;
  logic [DW-1:0]         rd_data;
  logic                  expire;

  assign addr_sel = epb_addr[SEL_W+SLAVE_AW-1:SLAVE_AW];
  assign mapped   = (int'(addr_sel) < NUM_SLAVES);
  assign ack_sel  = lb_ack_i[sel];
  assign rd_data  = lb_dat_i[int'(sel)*DW +: DW];

  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (k == int'(addr_sel)) onehot[k] = 1'b1;
    end
  end

`ifdef EPB_LB_TIMEOUT_EN
  epb_lb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (lb_clk),
    .rst    (lb_rst),
    .load   (state == ST_STROBE),
    .en     (state == ST_WAIT_ACK),
    .expire (expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign expire         = 1'b0;
`endif

  always_ff @(posedge lb_clk) begin
    if (lb_rst) begin
      state        <= ST_IDLE;
      armed        <= 1'b0;
      sel          <= '0;
      lb_stb_o     <= '0;
      lb_we_o      <= 1'b0;
      lb_adr_o     <= '0;
      lb_dat_o     <= '0;
      epb_data_o   <= '0;
      epb_data_oen <= 1'b0;
      epb_rdy      <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      // Only a fully observed access (cs_n seen high first) may start.
      if (epb_cs_n) armed <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (armed && !epb_cs_n && !epb_be_n) begin
            sel      <= addr_sel;
            lb_we_o  <= !epb_we_n;
            lb_adr_o <= epb_addr[SLAVE_AW-1:0];
            lb_dat_o <= epb_data_i;
            if (mapped) begin
              lb_stb_o <= onehot;
              state    <= ST_STROBE;
            end else begin
              bus_err      <= 1'b1;
              epb_data_o   <= UNMAPPED_DATA[DW-1:0];
              epb_data_oen <= epb_we_n;
              epb_rdy      <= 1'b1;
              state        <= ST_HOLD;
            end
          end
        end

        ST_STROBE, ST_WAIT_ACK: begin
          lb_stb_o <= '0;
          if (ack_sel) begin
            if (!lb_we_o) epb_data_o <= rd_data;
            epb_data_oen <= !lb_we_o;
            epb_rdy      <= 1'b1;
            state        <= ST_HOLD;
          end else if (expire) begin
            bus_err      <= 1'b1;
            epb_data_o   <= ERR_DATA[DW-1:0];
            epb_data_oen <= !lb_we_o;
            epb_rdy      <= 1'b1;
            state        <= ST_HOLD;
          end else begin
            state <= ST_WAIT_ACK;
          end
        end

        ST_HOLD: begin
          if (epb_cs_n) begin
            epb_rdy      <= 1'b0;
            epb_data_oen <= 1'b0;
            state        <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_epb_lb_bridge.sv
`default_nettype none
// ============================================================================
// tb_epb_lb_bridge : scoreboard bench for epb_lb_bridge (3 slaves, TIMEOUT=4)
// Rev 1.0
// ============================================================================
module tb_epb_lb_bridge;

  localparam int NS = 3;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cs_n = 1'b1, we_n = 1'b1, be_n = 1'b1;
  logic [4:0]      addr = '0;
  logic [DW-1:0]   data_i = '0;
  logic [DW-1:0]   data_o;
  logic            oen, rdy, berr;
  logic [NS-1:0]   stb;
  logic            lwe;
  logic [AW-1:0]   ladr;
  logic [DW-1:0]   ldat;
  logic [NS*DW-1:0] ldat_i = '0;
  logic [NS-1:0]   resp_ack = '0, stray_ack = '0;
  logic [NS-1:0]   ack;

  assign ack = resp_ack | stray_ack;

  epb_lb_bridge #(.NUM_SLAVES(NS), .SLAVE_AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .lb_clk(clk), .lb_rst(rst), .epb_cs_n(cs_n), .epb_we_n(we_n), .epb_be_n(be_n),
    .epb_addr(addr), .epb_data_i(data_i), .epb_data_o(data_o), .epb_data_oen(oen),
    .epb_rdy(rdy), .bus_err(berr), .lb_stb_o(stb), .lb_we_o(lwe), .lb_adr_o(ladr),
    .lb_dat_o(ldat), .lb_dat_i(ldat_i), .lb_ack_i(ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         err;
    bit         oen;
    int         lat;
    int         start;
  } exp_t;
  exp_t sb[$];

  // Slave-side responder: checks strobe contents and acks cfg_k cycles later.
  int          cfg_k = -1, cfg_sel = 0, cfg_adr = 0;
  bit          cfg_we = 0;
  logic [7:0]  cfg_wd = '0;
  bit          strobe_seen = 0;
  bit          prev_stb = 0;
  int          wait_cnt = -1;

  always @(negedge clk) begin
    resp_ack = '0;
    if (prev_stb) check_val("stb_one_cycle", 32'(stb), 32'd0);
    prev_stb = (stb != '0);
    if (prev_stb) begin
      strobe_seen = 1;
      check_val("stb_onehot", 32'(stb), 32'(1) << cfg_sel);
      check_val("lb_adr", 32'(ladr), 32'(cfg_adr));
      check_val("lb_we", 32'(lwe), 32'(cfg_we));
      if (cfg_we) check_val("lb_wdat", 32'(ldat), 32'(cfg_wd));
      wait_cnt = cfg_k;
    end else if (wait_cnt > 0) begin
      wait_cnt--;
    end
    if (wait_cnt == 0) begin
      resp_ack[cfg_sel] = 1'b1;
      wait_cnt = -1;
    end
  end

  // Scoreboard monitor: pops one expectation per epb_rdy rising edge.
  bit rdy_q = 0, err_next = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rdy && !rdy_q) begin
      check_val("sb_pop", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_val("rdy_latency", 32'(cyc - e.start), 32'(e.lat));
        check_val("bus_err", 32'(berr), 32'(e.err));
        check_val("data_oen", 32'(oen), 32'(e.oen));
        if (e.oen) check_val("rdata", 32'(data_o), 32'(e.data));
      end
      err_next = 1;
    end else if (err_next) begin
      check_val("err_pulse_end", 32'(berr), 32'd0);
      err_next = 0;
    end
    rdy_q = rdy;
  end

  function automatic logic [4:0] mk_addr(input int sel, input int adr);
    logic [1:0] s;
    logic [2:0] a;
    s = sel[1:0];
    a = adr[2:0];
    return {s, a};
  endfunction

  // Called on a negedge; returns on the negedge after cs_n has been released.
  task automatic access(input bit we, input int sel, input int adr, input logic [7:0] wd,
                        input logic [7:0] rd, input int k, input bit err,
                        input logic [7:0] exp_d, input int lat);
    exp_t e;
    cfg_k = k; cfg_sel = sel; cfg_adr = adr; cfg_we = we; cfg_wd = wd;
    strobe_seen = 0;
    ldat_i = {8'h5A, 8'h22, 8'h11};
    if (sel < NS) ldat_i[sel*DW +: DW] = rd;
    e.data = exp_d; e.err = err; e.oen = !we; e.lat = lat; e.start = cyc;
    sb.push_back(e);
    cs_n = 1'b0; be_n = 1'b0; we_n = !we; addr = mk_addr(sel, adr); data_i = wd;
    for (int i = 0; i < 40 && !rdy; i++) @(negedge clk);
    check_val("rdy_seen", 32'(rdy), 32'd1);
    check_val("strobe_issued", 32'(strobe_seen), 32'(sel < NS));
    if (sel < NS) ldat_i[sel*DW +: DW] = ~rd;
    data_i = 8'hEE;
    @(negedge clk);
    check_val("hold_rdy", 32'(rdy), 32'd1);
    check_val("hold_oen", 32'(oen), 32'(!we));
    if (!we) check_val("hold_data", 32'(data_o), 32'(exp_d));
    cs_n = 1'b1; be_n = 1'b1;
    @(negedge clk);
    check_val("rdy_release", 32'(rdy), 32'd0);
    check_val("oen_release", 32'(oen), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_rdy"}, 32'(rdy), 32'd0);
    check_val({tag, "_stb"}, 32'(stb), 32'd0);
    check_val({tag, "_err"}, 32'(berr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check_val("reset_data", 32'(data_o), 32'd0);
    check_val("reset_oen", 32'(oen), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    access(1, 1, 5, 8'hA5, 8'h00, 0, 0, 8'h00, 2);
    access(0, 2, 3, 8'h00, 8'h3C, 3, 0, 8'h3C, 5);
    access(0, 3, 1, 8'h00, 8'h00, 0, 1, 8'h00, 1);
    access(0, 0, 7, 8'h00, 8'h96, 1, 0, 8'h96, 3);
    access(1, 2, 0, 8'h5C, 8'h00, 2, 0, 8'h00, 4);
    access(1, 3, 2, 8'h81, 8'h00, 0, 1, 8'h00, 1);

    // Stray acks while idle, then a non-selected slave acking during an access.
    stray_ack = '1;
    repeat (3) @(negedge clk);
    check_quiet("idle_stray");
    stray_ack = 3'b001;
    access(0, 2, 6, 8'h00, 8'h4B, 2, 0, 8'h4B, 4);
    stray_ack = '0;

    // Ack on the expiry cycle completes normally.
    access(0, 1, 4, 8'h00, 8'h77, TO, 0, 8'h77, TO + 2);
`ifdef EPB_LB_TIMEOUT_EN
    access(0, 1, 2, 8'h00, 8'h12, -1, 1, 8'hFF, TO + 2);
    access(1, 0, 1, 8'h34, 8'h00, -1, 1, 8'hFF, TO + 2);
`endif

    // Reset while waiting for an ack with cs_n held low.
    cfg_k = -1; cfg_sel = 1; cfg_adr = 3; cfg_we = 0;
    cs_n = 1'b0; be_n = 1'b0; we_n = 1'b1; addr = mk_addr(1, 3);
`ifdef EPB_LB_TIMEOUT_EN
    repeat (3) @(negedge clk);
`else
    repeat (12) @(negedge clk);
`endif
    check_val("wait_no_rdy", 32'(rdy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    strobe_seen = 0;
    check_quiet("rst_mid");
    check_val("rst_mid_data", 32'(data_o), 32'd0);
    check_val("rst_mid_adr", 32'(ladr), 32'd0);
    repeat (4) @(negedge clk);
    check_val("disarmed_no_stb", 32'(strobe_seen), 32'd0);
    check_val("disarmed_no_rdy", 32'(rdy), 32'd0);
    cs_n = 1'b1; be_n = 1'b1;
    @(negedge clk);
    access(0, 0, 5, 8'h00, 8'hC3, 0, 0, 8'hC3, 2);

    repeat (3) @(negedge clk);
    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
